btn_sw_conditioner: RTL and testbench

//  Upstream stage of the user-design counter: turns raw button/switch pins into a clean counter enable.
//  - Synchronises and debounces io_in[PIN_BUTTON] and io_in[PIN_SWITCH].
//  - Emits en_out for the downstream counter: free-run toggle mode (switch=1), single-step mode (switch=0).

---
 rtl/pin_ctrl_pkg.sv | 44 ++++
 rtl/debounce_bit.sv | 45 ++++
 rtl/btn_sw_conditioner.sv | 116 +++++++++++
 tb/tb_btn_sw_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pin_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pin_ctrl_pkg : user-design pin map, output-enable levels, debounce state.
// Revision 1.0
// ============================================================================
package pin_ctrl_pkg;

    localparam int unsigned PIN_RESET  = 23;
    localparam int unsigned PIN_ENABLE = 22;
    localparam int unsigned PIN_SWITCH = 11;
    localparam int unsigned PIN_BUTTON = 10;

    localparam logic OUTPUT_ENABLE  = 1'b1;
    localparam logic OUTPUT_DISABLE = 1'b0;

    // Upper bound on the counter field; bits above $clog2(DEBOUNCE_CYCLES)
    // are never set because the count stops at DEBOUNCE_CYCLES-1.
    localparam int DEB_CNT_MAX_W = 32;

    typedef struct packed {
        logic                     d;
        logic [DEB_CNT_MAX_W-1:0] cnt;
    } deb_state_t;

    function automatic deb_state_t deb_next(
        input deb_state_t               cur,
        input logic                     s,
        input logic [DEB_CNT_MAX_W-1:0] last
    );
        deb_state_t nxt;
        nxt = cur;
        if (s == cur.d) begin
            nxt.cnt = '0;
        end else if (cur.cnt == last) begin
            nxt.d   = s;
            nxt.cnt = '0;
        end else begin
            nxt.cnt = cur.cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// debounce_bit : two-flop synchroniser followed by a stable-count debouncer.
// Revision 1.0
// ============================================================================
module debounce_bit
    import pin_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam logic [DEB_CNT_MAX_W-1:0] CNT_LAST = DEB_CNT_MAX_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("debounce_bit: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [1:0] sync_q, sync_d;
    deb_state_t state_q, state_d;

    always_comb begin
        sync_d  = {sync_q[0], raw ^ INVERT};
        state_d = deb_next(state_q, sync_q[1], CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
        end
    end

    assign level = state_q.d;

endmodule
`default_nettype wire

// File: rtl/btn_sw_conditioner.sv
`default_nettype none
// ============================================================================
// btn_sw_conditioner : debounced button/switch to counter enable (run/step).
// Optional long-press stop: define LONG_PRESS_DETECT_EN.   Revision 1.0
// ============================================================================
module btn_sw_conditioner
    import pin_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter bit BTN_ACTIVE_LOW    = 1'b0,
    parameter int LONG_PRESS_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic sw_raw,
    output logic btn_level,
    output logic sw_level,
    output logic btn_press,
    output logic en_out,
    output logic run,
    output logic long_press
);

    if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
        $error("btn_sw_conditioner: LONG_PRESS_CYCLES must be at least 1");
    end

    debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT         (BTN_ACTIVE_LOW)
    ) u_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_raw),
        .level(btn_level)
    );

    debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT         (1'b0)
    ) u_sw (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sw_raw),
        .level(sw_level)
    );

    logic btn_level_q, btn_level_d;
    logic run_q, run_d;

`ifdef LONG_PRESS_DETECT_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES);

    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            fired_q, fired_d;

    // Count stops at LP_LAST and freezes once fired, so one pulse per hold.
    always_comb begin
        long_press = btn_level && !fired_q && (lp_cnt_q == LP_LAST);
        lp_cnt_d   = lp_cnt_q;
        fired_d    = fired_q;
        if (!btn_level) begin
            lp_cnt_d = '0;
            fired_d  = 1'b0;
        end else if (long_press) begin
            fired_d  = 1'b1;
        end else if (!fired_q) begin
            lp_cnt_d = lp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt_q <= '0;
            fired_q  <= 1'b0;
        end else begin
            lp_cnt_q <= lp_cnt_d;
            fired_q  <= fired_d;
        end
    end
`else
    assign long_press = 1'b0;
`endif

    assign btn_press = btn_level & ~btn_level_q;

    // Switch-low beats long-press stop, which beats a toggle.
    always_comb begin
        btn_level_d = btn_level;
        run_d       = run_q;
        if (!sw_level) begin
            run_d = 1'b0;
        end else if (long_press) begin
            run_d = 1'b0;
        end else if (btn_press) begin
            run_d = ~run_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            btn_level_q <= btn_level_d;
            run_q       <= run_d;
        end
    end

    assign run    = run_q;
    assign en_out = sw_level ? run_q : btn_press;

endmodule
`default_nettype wire

// File: tb/tb_btn_sw_conditioner.sv
`default_nettype none
// ============================================================================
// tb_btn_sw_conditioner : vector table + scoreboard bench, DEBOUNCE_CYCLES=4.
// Revision 1.0
// ============================================================================
module tb_btn_sw_conditioner;

    localparam int DEB = 4;
    localparam int LPC = 10;
`ifdef LONG_PRESS_DETECT_EN
    localparam int LP_EN = 1;
`else
    localparam int LP_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n, btn_raw, sw_raw;
    logic btn_level, sw_level, btn_press, en_out, run, long_press;

    always #5 clk = ~clk;

    btn_sw_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .BTN_ACTIVE_LOW   (1'b0),
        .LONG_PRESS_CYCLES(LPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_level (btn_level),
        .sw_level  (sw_level),
        .btn_press (btn_press),
        .en_out    (en_out),
        .run       (run),
        .long_press(long_press)
    );

    // One step: hold pins for n cycles, then expect final levels/run and
    // the number of en_out and btn_press cycles seen during the step.
    typedef struct {
        logic btn;
        logic sw;
        int   n;
        int   e_btn;
        int   e_sw;
        int   e_run;
        int   e_en;
        int   e_press;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   en_cnt, press_cnt, lp_cnt;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic s);
        @(negedge clk);
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk);
        #1;
        en_cnt    += int'(en_out);
        press_cnt += int'(btn_press);
        lp_cnt    += int'(long_press);
    endtask

    task automatic add(input logic b, input logic s, input int n, input int eb,
                       input int es, input int er, input int ee, input int ep);
        vec_t v;
        v.btn = b; v.sw = s; v.n = n;
        v.e_btn = eb; v.e_sw = es; v.e_run = er; v.e_en = ee; v.e_press = ep;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v, e;
        int   rise, lpi;

        //   btn sw  n   btn sw run en press
        add(0, 0, 20, 0, 0, 0, 0,  0);   // idle after reset
        add(0, 1, 5,  0, 0, 0, 0,  0);   // switch edge, one short of latency
        add(0, 1, 1,  0, 1, 0, 0,  0);   // sw_level rises 6 clocks after edge
        add(1, 1, 8,  1, 1, 1, 2,  1);   // press toggles run on
        add(0, 1, 10, 0, 1, 1, 10, 0);   // free run, en continuous
        add(1, 1, 8,  1, 1, 0, 6,  1);   // second press stops run
        add(0, 1, 10, 0, 1, 0, 0,  0);
        add(1, 1, 2,  0, 1, 0, 0,  0);   // bounce 1,0,1,0
        add(0, 1, 2,  0, 1, 0, 0,  0);
        add(1, 1, 2,  0, 1, 0, 0,  0);
        add(0, 1, 2,  0, 1, 0, 0,  0);
        add(1, 1, 5,  0, 1, 0, 0,  0);   // final edge, not yet accepted
        add(1, 1, 3,  1, 1, 1, 2,  1);   // accepted on 6th cycle, one press
        add(0, 1, 10, 0, 1, 1, 10, 0);
        add(1, 1, 8,  1, 1, 0, 6,  1);   // run back to 0
        add(0, 1, 10, 0, 1, 0, 0,  0);
        add(1, 0, 6,  1, 0, 0, 1,  1);   // switch falls on the press cycle
        add(1, 0, 1,  1, 0, 0, 0,  0);   // switch-low wins over the toggle
        add(0, 0, 10, 0, 0, 0, 0,  0);
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 8, 1, 0, 0, 1, 1); // step mode: one en pulse per press
            add(0, 0, 8, 0, 0, 0, 0, 0);
        end
        add(0, 1, 10, 0, 1, 0, 0,  0);   // back to run mode for long press

        rst_n   = 1'b0;
        btn_raw = 1'b0;
        sw_raw  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset btn_level",  int'(btn_level),  0);
        check("reset sw_level",   int'(sw_level),   0);
        check("reset btn_press",  int'(btn_press),  0);
        check("reset en_out",     int'(en_out),     0);
        check("reset run",        int'(run),        0);
        check("reset long_press", int'(long_press), 0);
        rst_n = 1'b1;

        lp_cnt = 0;
        foreach (tbl[i]) begin
            v = tbl[i];
            sb.push_back(v);
            en_cnt    = 0;
            press_cnt = 0;
            repeat (v.n) cyc(v.btn, v.sw);
            e = sb.pop_front();
            check($sformatf("vec%0d btn_level", i), int'(btn_level), e.e_btn);
            check($sformatf("vec%0d sw_level", i),  int'(sw_level),  e.e_sw);
            check($sformatf("vec%0d run", i),       int'(run),       e.e_run);
            check($sformatf("vec%0d en_count", i),  en_cnt,          e.e_en);
            check($sformatf("vec%0d press_count", i), press_cnt,     e.e_press);
        end
        check("short holds long_press count", lp_cnt, 0);

        // Long hold: pulse 10 cycles after btn_level rises, stops run.
        en_cnt = 0; press_cnt = 0; lp_cnt = 0;
        rise = -1; lpi = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1, 1);
            if (btn_level && rise < 0) rise = k;
            if (long_press) lpi = k;
        end
        check("hold level rise cycle", rise, 6);
        check("hold long_press cycle", lpi, LP_EN ? rise + LPC : -1);
        check("hold long_press count", lp_cnt, LP_EN);
        check("hold press count", press_cnt, 1);
        check("hold run", int'(run), 1 - LP_EN);
        check("hold en count", en_cnt, LP_EN ? 10 : 14);

        en_cnt = 0; lp_cnt = 0;
        repeat (10) cyc(0, 1);
        check("release btn_level", int'(btn_level), 0);
        check("release run", int'(run), 1 - LP_EN);
        check("release en count", en_cnt, LP_EN ? 0 : 10);
        check("release long_press count", lp_cnt, 0);

        // Asynchronous reset in the middle of a button debounce.
        repeat (3) cyc(1, 1);
        check("pre-reset sw_level", int'(sw_level), 1);
        rst_n = 1'b0;
        #1;
        check("async btn_level",  int'(btn_level),  0);
        check("async sw_level",   int'(sw_level),   0);
        check("async btn_press",  int'(btn_press),  0);
        check("async en_out",     int'(en_out),     0);
        check("async run",        int'(run),        0);
        check("async long_press", int'(long_press), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        press_cnt = 0;
        repeat (5) cyc(1, 1);
        check("reacq early btn_level", int'(btn_level), 0);
        check("reacq early sw_level",  int'(sw_level),  0);
        cyc(1, 1);
        check("reacq btn_level",   int'(btn_level), 1);
        check("reacq sw_level",    int'(sw_level),  1);
        check("reacq press count", press_cnt,       1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
